frac_clken_gen: RTL and testbench
=================================

Name: frac_clken_gen

Overview:
Multi-channel rational clock-enable generator running on one PLL output clock (e.g. 53.693175 MHz). Each channel emits single-cycle enable pulses at exact ratio NUM/DEN of the master clock, for example 1/7 for the 68k and 1/15 for the Z80. It is the parametrised successor to a fixed-output PLL: ratios are changed at runtime through a handshaked config port without reconfiguring the PLL. Updates are glitch-free, applied only on pulse boundaries. A global sync realigns all channels.

Parameters:
NCH, 4, number of enable channels (1..16)
ACC_W, 16, width of NUM, DEN and accumulator
CH_W, 2, channel index width, equals clog2(NCH) with a minimum of 1

Ports:
refclk  in  1  master clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request can be accepted this cycle
cfg_ch  in  CH_W  target channel
cfg_num  in  ACC_W  numerator
cfg_den  in  ACC_W  denominator
cfg_err  out  1  one-cycle pulse: rejected config
sync  in  1  realign all channels
ce  out  NCH  enable pulses, one bit per channel
active  out  NCH  channel running (num != 0)

Behaviour:
- Reset values (rst=1 at a clock edge):
  - every channel: num=0, den=1, acc=0, pend=0
  - ce=0, active=0, cfg_err=0, cfg_ready=1
  - rst overrides all other inputs in the same cycle, including mid-pulse and with pending configs; pending configs are dropped.
- Per-channel step, each cycle when active and no sync:
  - sum = acc + num, computed ACC_W+1 bits wide, no overflow.
  - If sum >= den: acc <= sum - den and ce[ch] <= 1.
  - Else: acc <= sum and ce[ch] <= 0.
  - ce is registered: it goes high the cycle after the accumulating edge. Exactly num pulses per den cycles; num==den gives ce stuck high.
- Inactive channel (num==0): acc held, ce=0, active=0.
- Handshake:
  - cfg_ready = !pend[cfg_ch], combinational on cfg_ch.
  - Transfer occurs when cfg_valid && cfg_ready.
- Validity check on transfer:
  - Invalid if den==0 or num>den.
  - Invalid transfer: cfg_err=1 on the next cycle; channel state unchanged.
  - Valid transfer: pending num/den latched and pend set.
- Applying a pending config:
  - Applied on the cycle the channel's overflow produces a pulse, i.e. the same edge that sets ce.
  - New num/den are loaded and acc <= 0; that pulse is still emitted.
  - If the channel is inactive, it is applied on the cycle after acceptance.
  - pend clears when applied. Writing num=0 stops the channel at its next boundary.
- sync=1:
  - All acc <= 0, all ce <= 0 for that cycle, all pending configs applied immediately.
  - The first pulses after sync follow the new phase, so channels with the same ratio pulse together.
- Simultaneous sync and valid transfer in the same cycle: the new config is applied by that sync.
- Simultaneous pulse boundary and transfer on the same channel: impossible, since cfg_ready=0 while pend is set. A transfer into an empty pend at a boundary waits for the next boundary.
- active[ch] is a registered copy of num!=0 and updates in the cycle the config is applied.

Decomposition:
- Package frac_clken_pkg holds:
  - ACC_W and NCH defaults
  - cfg record type {num, den}
  - reset constants (num=0, den=1)
  - validity function (den!=0 && num<=den)
- Sub-module frac_clken_ch holds one channel: acc, num/den, pending register, boundary/apply logic. The top level generates NCH instances, decodes cfg_ch, muxes cfg_ready and registers cfg_err.

Test Plan:
- Divide by 7: write ch0 num=1 den=7 → after apply, ce[0] pulses every 7th cycle; 100 cycles give 14 pulses; active[0]=1.
- Fractional ratio: ch1 num=3 den=8 → pulse pattern repeats every 8 cycles with exactly 3 pulses; 800 cycles give 300 pulses.
- Mid-run change: ch0 at 1/7, then write 1/15 → cfg_ready[ch0 addressed]=0 until the next ch0 pulse; that pulse is emitted; the following gap is exactly 15 cycles; no runt or double pulse.
- Invalid config: num=5 den=4, and separately den=0 → cfg_err high one cycle; ce timing of the target channel unchanged; pend not set.
- Sync realign: ch2 and ch3 both 1/4 but out of phase → pulse sync → both ce low that cycle, then coincident pulses every 4 cycles.
- Reset mid-operation: assert rst with ch0 running and ch1 pending → next cycle ce=0, active=0, cfg_ready=1; the pending config is never applied.

Source files
------------

// File: rtl/frac_clken_pkg.sv
// Shared constants, config record and validity rule for the rational clock-enable generator.
package frac_clken_pkg;

   localparam int NCH_DEF   = 4;
   localparam int ACC_W_DEF = 16;
   localparam int NUM_RST   = 0;
   localparam int DEN_RST   = 1;

   typedef struct packed {
      logic [ACC_W_DEF-1:0] num;
      logic [ACC_W_DEF-1:0] den;
   } cfg_t;

   // A ratio above one would need more than one pulse per cycle.
   function automatic logic cfg_ok(input logic [31:0] num, input logic [31:0] den);
      return (den != 32'd0) && (num <= den);
   endfunction

endpackage

// File: rtl/frac_clken_ch.sv
// One rational enable channel: phase accumulator plus a pending ratio applied on pulse boundaries.
module frac_clken_ch
   import frac_clken_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             wr_en,
   input  logic [ACC_W-1:0] wr_num,
   input  logic [ACC_W-1:0] wr_den,
   output logic             pend,
   output logic             ce,
   output logic             active
);

   logic [ACC_W-1:0] num, den, acc, pnum, pden;
   logic [ACC_W:0]   sum;
   logic             run, boundary, apply;

   assign run      = (num != '0);
   assign sum      = {1'b0, acc} + {1'b0, num};
   assign boundary = run && (sum >= {1'b0, den});
   // An idle channel has no boundary to wait for, so it takes the new ratio at once.
   assign apply    = pend && (sync || boundary || !run);
   assign active   = run;

   always_ff @(posedge clk) begin
      if (rst) begin
         num  <= ACC_W'(NUM_RST);
         den  <= ACC_W'(DEN_RST);
         acc  <= '0;
         pnum <= '0;
         pden <= '0;
         pend <= 1'b0;
         ce   <= 1'b0;
      end else begin
         if (sync) begin
            acc <= '0;
            ce  <= 1'b0;
         end else if (run) begin
            ce  <= boundary;
            acc <= boundary ? ACC_W'(sum - {1'b0, den}) : sum[ACC_W-1:0];
         end else begin
            ce  <= 1'b0;
         end

         // wr_en only arrives while pend is clear, so it never collides with apply.
         if (sync && wr_en) begin
            num <= wr_num;
            den <= wr_den;
         end else if (apply) begin
            num  <= pnum;
            den  <= pden;
            acc  <= '0;
            pend <= 1'b0;
         end else if (wr_en) begin
            pnum <= wr_num;
            pden <= wr_den;
            pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel rational clock-enable generator with a handshaked ratio port and global realign.
module frac_clken_gen
   import frac_clken_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [ACC_W-1:0] cfg_num,
   input  logic [ACC_W-1:0] cfg_den,
   output logic             cfg_err,
   input  logic             sync,
   output logic [NCH-1:0]   ce,
   output logic [NCH-1:0]   active
);

   logic [NCH-1:0] pend, wr_en;
   logic           ch_hit, xfer, cfg_good;

   // Indices past NCH are accepted and then flagged, so the port never stalls.
   always_comb begin
      cfg_ready = 1'b1;
      ch_hit    = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !pend[i];
            ch_hit    = 1'b1;
         end
      end
   end

   assign xfer     = cfg_valid && cfg_ready;
   assign cfg_good = ch_hit && cfg_ok(32'(cfg_num), 32'(cfg_den));

   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NCH; i++) begin
         wr_en[i] = xfer && cfg_good && (cfg_ch == CH_W'(i));
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) cfg_err <= 1'b0;
      else     cfg_err <= xfer && !cfg_good;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      frac_clken_ch #(
         .ACC_W (ACC_W)
      ) u_ch (
         .clk    (refclk),
         .rst    (rst),
         .sync   (sync),
         .wr_en  (wr_en[g]),
         .wr_num (cfg_num),
         .wr_den (cfg_den),
         .pend   (pend[g]),
         .ce     (ce[g]),
         .active (active[g])
      );
   end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Bench for frac_clken_gen: directed ratio scenarios plus random traffic against a floor-division model.
module tb_frac_clken_gen;
   import frac_clken_pkg::*;

   localparam int NCH   = 4;
   localparam int ACC_W = 16;
   localparam int CH_W  = 2;

   logic             refclk = 1'b0;
   logic             rst = 1'b1, sync = 1'b0, cfg_valid = 1'b0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [ACC_W-1:0] cfg_num = '0, cfg_den = '0;
   logic             cfg_ready, cfg_err;
   logic [NCH-1:0]   ce, active;

   int n_tests = 0;
   int n_fail  = 0;

   frac_clken_gen #(.NCH(NCH), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_num   (cfg_num),
      .cfg_den   (cfg_den),
      .cfg_err   (cfg_err),
      .sync      (sync),
      .ce        (ce),
      .active    (active)
   );

   always #5 refclk = ~refclk;

   // Model: a running channel pulses on step n when floor(n*num/den) advances.
   int             m_num[NCH], m_den[NCH];
   longint         m_n[NCH];
   bit             m_pend[NCH];
   cfg_t           m_pcfg[NCH];
   logic [NCH-1:0] exp_ce, exp_act;
   logic           exp_err;

   task automatic model_apply(input int c);
      m_num[c]  = int'(m_pcfg[c].num);
      m_den[c]  = int'(m_pcfg[c].den);
      m_pend[c] = 1'b0;
      m_n[c]    = 0;
   endtask

   task automatic model_step();
      bit xfer, ok, wr, hit;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_num[c] = 0; m_den[c] = 1; m_n[c] = 0; m_pend[c] = 1'b0;
         end
         exp_ce  = '0;
         exp_err = 1'b0;
      end else begin
         xfer    = cfg_valid && !m_pend[cfg_ch];
         ok      = (cfg_den != 0) && (cfg_num <= cfg_den);
         exp_err = xfer && !ok;
         for (int c = 0; c < NCH; c++) begin
            wr = xfer && ok && (int'(cfg_ch) == c);
            if (sync) begin
               exp_ce[c] = 1'b0;
               m_n[c]    = 0;
               if (wr) begin
                  m_num[c] = int'(cfg_num);
                  m_den[c] = int'(cfg_den);
               end else if (m_pend[c]) model_apply(c);
            end else if (m_num[c] != 0) begin
               m_n[c]++;
               hit = ((m_n[c] * m_num[c]) / m_den[c]) != (((m_n[c] - 1) * m_num[c]) / m_den[c]);
               exp_ce[c] = hit;
               if (hit && m_pend[c]) model_apply(c);
               else if (wr) begin
                  m_pcfg[c].num = cfg_num; m_pcfg[c].den = cfg_den; m_pend[c] = 1'b1;
               end
            end else begin
               exp_ce[c] = 1'b0;
               if (m_pend[c]) model_apply(c);
               else if (wr) begin
                  m_pcfg[c].num = cfg_num; m_pcfg[c].den = cfg_den; m_pend[c] = 1'b1;
               end
            end
         end
      end
      for (int c = 0; c < NCH; c++) exp_act[c] = (m_num[c] != 0);
   endtask

   always @(posedge refclk) model_step();

   task automatic cycle();
      @(posedge refclk);
      #1;
   endtask

   task automatic write_cfg(input int ch, input int num, input int den);
      int w = 0;
      cfg_ch = CH_W'(ch); cfg_num = ACC_W'(num); cfg_den = ACC_W'(den); cfg_valid = 1'b1;
      #1;
      while (!cfg_ready && w < 200) begin
         cycle();
         w++;
      end
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL write_cfg_wait ch%0d: cfg_ready=%b, required 1 within 200 cycles", ch, cfg_ready);
      end
      cycle();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
      cycle(); cycle();
      n_tests++;
      if (ce !== '0 || active !== '0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ce=%b active=%b err=%b, required 0000 0000 0", ce, active, cfg_err);
      end
      for (int c = 0; c < NCH; c++) begin
         cfg_ch = CH_W'(c);
         #1;
         n_tests++;
         if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready ch%0d: cfg_ready=%b, required 1", c, cfg_ready);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_div7();
      int cnt = 0, bad = 0;
      write_cfg(0, 1, 7);
      cycle();
      n_tests++;
      if (active[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL div7_active: active[0]=%b, required 1", active[0]);
      end
      for (int i = 0; i < 100; i++) begin
         cycle();
         cnt += int'(ce[0]);
         if (ce !== exp_ce || active !== exp_act) bad++;
      end
      n_tests++;
      if (cnt != 14) begin
         n_fail++;
         $display("FAIL div7_count: pulses=%0d, required 14", cnt);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL div7_trace: mismatching cycles=%0d, required 0", bad);
      end
   endtask

   task automatic test_frac();
      int cnt = 0, win = 0, bad_win = 0, bad = 0;
      write_cfg(1, 3, 8);
      cycle();
      for (int i = 1; i <= 800; i++) begin
         cycle();
         cnt += int'(ce[1]);
         win += int'(ce[1]);
         if (i % 8 == 0) begin
            if (win != 3) bad_win++;
            win = 0;
         end
         if (ce !== exp_ce) bad++;
      end
      n_tests++;
      if (cnt != 300) begin
         n_fail++;
         $display("FAIL frac_count: pulses=%0d, required 300", cnt);
      end
      n_tests++;
      if (bad_win != 0) begin
         n_fail++;
         $display("FAIL frac_window: 8-cycle windows without 3 pulses=%0d, required 0", bad_win);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL frac_trace: mismatching cycles=%0d, required 0", bad);
      end
   endtask

   task automatic test_midrun();
      int  bad_rdy = 0, gap = 0, extra = 0;
      bit  seen = 1'b0;
      write_cfg(0, 1, 15);
      for (int i = 0; i < 20 && !seen; i++) begin
         if (cfg_ready !== 1'b0) bad_rdy++;
         cycle();
         seen = ce[0];
      end
      n_tests++;
      if (!seen || bad_rdy != 0) begin
         n_fail++;
         $display("FAIL midrun_hold: boundary pulse seen=%b ready-high cycles=%0d, required 1 and 0", seen, bad_rdy);
      end
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_release: cfg_ready=%b at apply pulse, required 1", cfg_ready);
      end
      seen = 1'b0;
      while (!seen && gap < 40) begin
         cycle();
         gap++;
         seen = ce[0];
         if (ce !== exp_ce) extra++;
      end
      n_tests++;
      if (gap != 15) begin
         n_fail++;
         $display("FAIL midrun_gap: gap=%0d cycles, required 15", gap);
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL midrun_trace: mismatching cycles=%0d, required 0", extra);
      end
   endtask

   task automatic test_invalid();
      int cnt = 0, bad = 0;
      int nums[2] = '{5, 3};
      int dens[2] = '{4, 0};
      for (int k = 0; k < 2; k++) begin
         cfg_ch = CH_W'(1); cfg_num = ACC_W'(nums[k]); cfg_den = ACC_W'(dens[k]); cfg_valid = 1'b1;
         cycle();
         n_tests++;
         if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_reject %0d/%0d: err=%b ready=%b, required 1 1", nums[k], dens[k], cfg_err, cfg_ready);
         end
         cfg_valid = 1'b0;
         cycle();
         n_tests++;
         if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_err_width %0d/%0d: err=%b, required 0", nums[k], dens[k], cfg_err);
         end
      end
      for (int i = 0; i < 16; i++) begin
         cycle();
         cnt += int'(ce[1]);
         if (ce !== exp_ce || active !== exp_act) bad++;
      end
      n_tests++;
      if (cnt != 6 || bad != 0) begin
         n_fail++;
         $display("FAIL invalid_unchanged: ch1 pulses=%0d mismatches=%0d, required 6 and 0", cnt, bad);
      end
   endtask

   task automatic test_sync();
      int diff = 0, cnt = 0, bad = 0;
      write_cfg(2, 1, 4);
      cycle(); cycle();
      write_cfg(3, 1, 4);
      repeat (4) cycle();
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (ce[2] != ce[3]) diff++;
      end
      n_tests++;
      if (diff != 4) begin
         n_fail++;
         $display("FAIL sync_pre_phase: disagreeing cycles=%0d, required 4", diff);
      end
      sync = 1'b1;
      cfg_ch = CH_W'(0); cfg_num = '0; cfg_den = ACC_W'(1); cfg_valid = 1'b1;
      cycle();
      sync = 1'b0; cfg_valid = 1'b0;
      n_tests++;
      if (ce !== '0 || active !== 4'b1110) begin
         n_fail++;
         $display("FAIL sync_cycle: ce=%b active=%b, required 0000 1110", ce, active);
      end
      diff = 0;
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (ce[2] != ce[3]) diff++;
         cnt += int'(ce[2]);
         if (ce !== exp_ce || active !== exp_act) bad++;
      end
      n_tests++;
      if (diff != 0 || cnt != 4) begin
         n_fail++;
         $display("FAIL sync_aligned: disagreeing=%0d ch2 pulses=%0d, required 0 and 4", diff, cnt);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL sync_trace: mismatching cycles=%0d, required 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      write_cfg(0, 1, 5);
      repeat (6) cycle();
      write_cfg(1, 2, 3);
      n_tests++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_pending: ch1 cfg_ready=%b, required 0", cfg_ready);
      end
      rst = 1'b1;
      cycle();
      n_tests++;
      if (ce !== '0 || active !== '0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: ce=%b active=%b err=%b, required 0000 0000 0", ce, active, cfg_err);
      end
      for (int c = 0; c < NCH; c++) begin
         cfg_ch = CH_W'(c);
         #1;
         if (cfg_ready !== 1'b1) bad++;
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (ce !== '0 || active !== '0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_mid_dropped: nonzero ready/ce/active observations=%0d, required 0", bad);
      end
   endtask

   task automatic test_random();
      int bad_o = 0, bad_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if (ce !== exp_ce || active !== exp_act || cfg_err !== exp_err) bad_o++;
         rst       = ($urandom_range(0, 499) == 0);
         sync      = ($urandom_range(0, 59) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
         cfg_num   = ACC_W'($urandom_range(0, 6));
         cfg_den   = ACC_W'($urandom_range(0, 6));
         #1;
         if (cfg_ready !== !m_pend[cfg_ch]) bad_r++;
         @(posedge refclk);
         #1;
      end
      rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
      n_tests++;
      if (bad_o != 0) begin
         n_fail++;
         $display("FAIL random_outputs: mismatching cycles=%0d, required 0", bad_o);
      end
      n_tests++;
      if (bad_r != 0) begin
         n_fail++;
         $display("FAIL random_ready: mismatching cycles=%0d, required 0", bad_r);
      end
   endtask

   initial begin
      test_reset();
      test_div7();
      test_frac();
      test_midrun();
      test_invalid();
      test_sync();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at 1000000, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
